// File: rtl/q_link_pkg.sv
// Shared definitions for the serialized-charge link: FSM state encoding,
// default link constants and the timer sizing helper.
package q_link_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HIGH    = 3'd1,
      LOW     = 3'd2,
      END_GAP = 3'd3,
      DONE    = 3'd4
   } link_state_t;

   // Charge units carried by one pulse, and how long each pulse stays high.
   // The receiver and the emulation model import these same values.
   localparam int LINK_Q_PER_PULSE    = 30;
   localparam int LINK_PULSE_DURATION = 3;

   // Width of a timer able to count the longest of the three phase durations.
   function automatic int timer_width(input int pulse_cycles,
                                      input int gap_cycles,
                                      input int frame_gap_cycles);
      int longest;
      longest = pulse_cycles;
      if (gap_cycles > longest) longest = gap_cycles;
      if (frame_gap_cycles > longest) longest = frame_gap_cycles;
      return $clog2(longest + 1);
   endfunction

endpackage

// File: rtl/link_timer.sv
// Loadable down-counter. A load sets the count; the counter then walks down
// to zero and parks there. expired is high while the count is zero.
module link_timer #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             expired
);

   logic [WIDTH-1:0] count;

   // Count down after each load, saturating at zero.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count != '0) begin
         count <= count - WIDTH'(1);
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/q_pulse_serializer.sv
// Transmit end of the serialized-charge link. A parallel charge value is
// turned into a train of fixed-width pulses, one per Q_PER_PULSE units,
// followed by a low guard interval long enough for the receiver watchdog
// to close the frame. The part of the charge smaller than one pulse is
// reported on q_remainder.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start; outputs low
// HIGH    | q_serialized high for PULSE_DURATION cycles
// LOW     | inter-pulse gap, GAP_DURATION cycles
// END_GAP | frame guard interval, FRAME_GAP cycles
// DONE    | one-cycle done strobe, then back to IDLE
module q_pulse_serializer
   import q_link_pkg::*;
#(
   parameter int BUS_WIDTH      = 10,
   parameter int Q_PER_PULSE    = LINK_Q_PER_PULSE,
   parameter int PULSE_DURATION = LINK_PULSE_DURATION,
   parameter int GAP_DURATION   = 3,
   parameter int FRAME_GAP      = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [BUS_WIDTH-1:0] q_value,
   output logic                 q_serialized,
   output logic                 busy,
   output logic                 done,
   output logic [BUS_WIDTH-1:0] q_remainder
);

   localparam int TW = timer_width(PULSE_DURATION, GAP_DURATION, FRAME_GAP);

   // Timer reload values: the timer reads zero in the final cycle of a phase.
   localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_DURATION - 1);
   localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_DURATION - 1);
   localparam logic [TW-1:0] FRAME_LOAD = TW'(FRAME_GAP - 1);

   // A pulse quantum wider than the input range can never be reached; it is
   // flagged here so the truncated constant below is never used to compare.
   localparam bit              Q_TOO_BIG = (Q_PER_PULSE > (2 ** BUS_WIDTH) - 1);
   localparam logic [BUS_WIDTH:0] Q_EXT  = (BUS_WIDTH + 1)'(Q_PER_PULSE);

   link_state_t         state;
   logic [BUS_WIDTH:0]  res;
   logic [BUS_WIDTH:0]  q_ext;
   logic                q_fits;
   logic                res_fits;
   logic                timer_load;
   logic [TW-1:0]       timer_value;
   logic                expired;

   // Compares carry one extra bit so the subtraction can never wrap.
   assign q_ext    = {1'b0, q_value};
   assign q_fits   = !Q_TOO_BIG && (q_ext >= Q_EXT);
   assign res_fits = !Q_TOO_BIG && (res >= Q_EXT);

   // Reload the shared phase timer on every state entry with that phase's length.
   always_comb begin
      timer_load  = 1'b0;
      timer_value = '0;
      case (state)
         IDLE: begin
            if (start) begin
               timer_load  = 1'b1;
               timer_value = q_fits ? PULSE_LOAD : FRAME_LOAD;
            end
         end
         HIGH: begin
            if (expired) begin
               timer_load  = 1'b1;
               timer_value = GAP_LOAD;
            end
         end
         LOW: begin
            if (expired) begin
               timer_load  = 1'b1;
               timer_value = res_fits ? PULSE_LOAD : FRAME_LOAD;
            end
         end
         END_GAP: begin
            if (expired) begin
               timer_load  = 1'b1;
               timer_value = '0;
            end
         end
         default: begin
            timer_load  = 1'b0;
            timer_value = '0;
         end
      endcase
   end

   link_timer #(
      .WIDTH (TW)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load       (timer_load),
      .load_value (timer_value),
      .expired    (expired)
   );

   // Frame sequencer; outputs are set on the transition into each state so
   // they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         res          <= '0;
         q_serialized <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         q_remainder  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (q_fits) begin
                     state        <= HIGH;
                     res          <= q_ext - Q_EXT;
                     q_serialized <= 1'b1;
                  end else begin
                     state <= END_GAP;
                     res   <= q_ext;
                  end
               end
            end
            HIGH: begin
               if (expired) begin
                  state        <= LOW;
                  q_serialized <= 1'b0;
               end
            end
            LOW: begin
               if (expired) begin
                  if (res_fits) begin
                     state        <= HIGH;
                     res          <= res - Q_EXT;
                     q_serialized <= 1'b1;
                  end else begin
                     state <= END_GAP;
                  end
               end
            end
            END_GAP: begin
               if (expired) begin
                  state <= DONE;
                  done  <= 1'b1;
                  // Published together with done so it is valid during the strobe.
                  q_remainder <= res[BUS_WIDTH-1:0];
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state        <= IDLE;
               q_serialized <= 1'b0;
               busy         <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_q_pulse_serializer.sv
// Directed bench for q_pulse_serializer: default instance plus a fast
// instance with one-unit pulses and one-cycle phases.
module tb_q_pulse_serializer;

   logic       clk     = 1'b0;
   logic       rst     = 1'b0;
   logic       start_d = 1'b0;
   logic       start_f = 1'b0;
   logic [9:0] q_value = '0;

   logic       ser_d, busy_d, done_d;
   logic [9:0] rem_d;
   logic       ser_f, busy_f, done_f;
   logic [9:0] rem_f;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   q_pulse_serializer dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start_d),
      .q_value      (q_value),
      .q_serialized (ser_d),
      .busy         (busy_d),
      .done         (done_d),
      .q_remainder  (rem_d)
   );

   q_pulse_serializer #(
      .Q_PER_PULSE    (1),
      .PULSE_DURATION (1),
      .GAP_DURATION   (1)
   ) dut_fast (
      .clk          (clk),
      .rst          (rst),
      .start        (start_f),
      .q_value      (q_value),
      .q_serialized (ser_f),
      .busy         (busy_f),
      .done         (done_f),
      .q_remainder  (rem_f)
   );

   task automatic check(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Runs one frame; cycle c is the c-th falling edge after the start edge E0.
   task automatic measure(input string tag, input bit fast, input int v,
                          input int exp_n, input int exp_rem, input bit hold);
      int   pd, gd, exp_done, hi_cnt, pulses, shape_err;
      int   done_cyc, rem_seen, busy_after, ser_after;
      logic ser, prev, exp_ser;
      pd         = fast ? 1 : 3;
      gd         = fast ? 1 : 3;
      exp_done   = exp_n * (pd + gd) + 8 + 1;
      hi_cnt     = 0;
      pulses     = 0;
      shape_err  = 0;
      done_cyc   = 0;
      rem_seen   = -1;
      busy_after = -1;
      ser_after  = -1;
      prev       = 1'b0;
      @(negedge clk);
      q_value = 10'(v);
      if (fast) start_f = 1'b1;
      else      start_d = 1'b1;
      for (int c = 1; c <= 400; c++) begin
         @(negedge clk);
         if (!hold) begin
            start_d = 1'b0;
            start_f = 1'b0;
         end
         ser     = fast ? ser_f : ser_d;
         exp_ser = (c <= exp_n * (pd + gd)) && (((c - 1) % (pd + gd)) < pd);
         if (ser !== exp_ser) shape_err++;
         if (ser === 1'b1) hi_cnt++;
         if (ser === 1'b1 && prev !== 1'b1) pulses++;
         prev = ser;
         if (done_cyc == 0) begin
            if ((fast ? done_f : done_d) === 1'b1) begin
               done_cyc = c;
               rem_seen = int'(fast ? rem_f : rem_d);
            end
         end else begin
            busy_after = int'(fast ? busy_f : busy_d);
            ser_after  = int'(ser);
            break;
         end
      end
      if (!hold) begin
         start_d = 1'b0;
         start_f = 1'b0;
      end
      check({tag, "_pulses"},     pulses,     exp_n);
      check({tag, "_high_cycles"}, hi_cnt,    exp_n * pd);
      check({tag, "_shape_errs"}, shape_err,  0);
      check({tag, "_done_cycle"}, done_cyc,   exp_done);
      check({tag, "_remainder"},  rem_seen,   exp_rem);
      check({tag, "_busy_after"}, busy_after, 0);
      check({tag, "_ser_after"},  ser_after,  0);
   endtask

   int done_c;
   int done_count;

   initial begin
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_ser",  int'(ser_d),  0);
      check("reset_busy", int'(busy_d), 0);
      check("reset_done", int'(done_d), 0);
      check("reset_rem",  int'(rem_d),  0);
      check("reset_fast_ser",  int'(ser_f),  0);
      check("reset_fast_busy", int'(busy_f), 0);
      rst = 1'b1;
      @(negedge clk);

      measure("q90",   1'b0, 90,   3,  0,  1'b0);
      measure("q29",   1'b0, 29,   0,  29, 1'b0);
      measure("q0",    1'b0, 0,    0,  0,  1'b0);
      measure("q30",   1'b0, 30,   1,  0,  1'b0);
      measure("q59",   1'b0, 59,   1,  29, 1'b0);
      measure("q1023", 1'b0, 1023, 34, 3,  1'b0);

      // start held through a whole frame: the retrigger lands one cycle after DONE
      measure("q60_hold", 1'b0, 60, 2, 0, 1'b1);
      @(negedge clk);
      check("restart_ser",  int'(ser_d),  1);
      check("restart_busy", int'(busy_d), 1);
      start_d = 1'b0;
      done_c  = 0;
      for (int c = 2; c <= 100; c++) begin
         @(negedge clk);
         if (done_d === 1'b1) begin
            done_c = c;
            break;
         end
      end
      check("restart_done_cycle", done_c, 21);
      @(negedge clk);
      check("restart_rem", int'(rem_d), 0);

      // reset in the middle of the second pulse of a 150-unit frame
      @(negedge clk);
      q_value = 10'd150;
      start_d = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         start_d = 1'b0;
      end
      check("mid_pulse2_ser", int'(ser_d), 1);
      rst = 1'b0;
      @(negedge clk);
      check("abort_ser",  int'(ser_d),  0);
      check("abort_busy", int'(busy_d), 0);
      check("abort_done", int'(done_d), 0);
      done_count = 0;
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done_d === 1'b1) done_count++;
      end
      check("abort_no_done", done_count, 0);
      measure("q150_after_rst", 1'b0, 150, 5, 0, 1'b0);

      measure("fast_q5", 1'b1, 5, 5, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
